iq_comp_seq: RTL and testbench
==============================

Name: iq_comp_seq

Overview:
Calibration sequencer for the iq_comp IQ-imbalance compensator in the 16 MHz receive path.
- Drives iq_comp's op_mode, freeze_iqcomp, Wr_in and Wj_in.
- Runs an adaptive calibration and waits until iq_comp reports settled for a qualified window, or a timeout expires.
- Captures the converged Wr/Wj weights and switches iq_comp to static mode using them.
- Also accepts host-loaded weights, and provides abort and re-calibration.

Parameters:
- W_WIDTH, 13: signed weight width; matches iq_comp Wr/Wj.
- SETTLE_CYC, 16: consecutive cycles settled must be high to qualify convergence; range 1..255.
- TIMEOUT_CYC, 4096: maximum calibration cycles before giving up; range 1..65535.

Ports:
- clk, input, 1: 16 MHz sample clock.
- RESETn, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that starts calibration.
- abort, input, 1: level; forces a return to BYPASS.
- load_en, input, 1: one-cycle pulse that loads Wr_load/Wj_load and enters STATIC.
- Wr_load, input, W_WIDTH (signed): host real weight.
- Wj_load, input, W_WIDTH (signed): host imaginary weight.
- settled, input, 1: from iq_comp.
- Wr_est, input, W_WIDTH (signed): iq_comp Wr output.
- Wj_est, input, W_WIDTH (signed): iq_comp Wj output.
- op_mode, output, 2: to iq_comp. 00 = bypass, 01 = adaptive, 10 = static (uses Wr_in/Wj_in), 11 unused.
- freeze_iqcomp, output, 1: to iq_comp.
- Wr_cfg, output, W_WIDTH (signed): to iq_comp Wr_in.
- Wj_cfg, output, W_WIDTH (signed): to iq_comp Wj_in.
- busy, output, 1: high in ADAPT and CAPTURE.
- done, output, 1: one-cycle pulse on entry to STATIC from CAPTURE.
- timeout_err, output, 1: sticky; cleared by start, load_en, or reset.
- state_o, output, 3: current state encoding, for debug.

Behaviour:
- All outputs are registered. Reset values:
  - op_mode = 00, freeze_iqcomp = 0, Wr_cfg = Wj_cfg = 0.
  - busy = 0, done = 0, timeout_err = 0.
  - state = BYPASS (state_o = 0); counters = 0.
- State encodings: BYPASS = 0, ADAPT = 1, CAPTURE = 2, STATIC = 3, FAIL = 4.
- Priority each cycle: abort > load_en > start > internal conditions.
- abort (any state): next state BYPASS, op_mode = 00, freeze = 0, busy = 0. Wr_cfg/Wj_cfg are retained.
- load_en (any state, abort low):
  - Wr_cfg <= Wr_load, Wj_cfg <= Wj_load; state STATIC; op_mode = 10; freeze = 1.
  - Clears counters and timeout_err; done is not asserted.
- BYPASS: on start go to ADAPT, with op_mode = 01, freeze = 0, busy = 1; timeout_cnt and settle_cnt cleared; timeout_err cleared.
- ADAPT, per cycle:
  - timeout_cnt increments.
  - settle_cnt increments while settled = 1 and saturates at SETTLE_CYC; it resets to 0 on any cycle settled = 0.
  - When settle_cnt reaches SETTLE_CYC, go to CAPTURE next cycle, with freeze = 1 and op_mode = 01.
  - Otherwise, when timeout_cnt reaches TIMEOUT_CYC, go to FAIL: op_mode = 00, freeze = 0, busy = 0, timeout_err = 1.
  - If both conditions hit on the same cycle, settling wins (CAPTURE).
  - start while in ADAPT restarts the calibration: counters cleared, state stays ADAPT.
- CAPTURE (exactly 2 cycles):
  - Cycle 1 waits for the freeze to take effect in iq_comp.
  - Cycle 2 samples Wr_cfg <= Wr_est and Wj_cfg <= Wj_est, then goes to STATIC with op_mode = 10, freeze = 1, busy = 0, and done pulses for 1 cycle.
- Latency: from the settled-qualifying cycle to op_mode = 10 is 3 clk cycles.
- STATIC: holds the configuration. start re-enters ADAPT; Wr_cfg/Wj_cfg keep their last values until recaptured.
- FAIL: op_mode = 00; waits for start (goes to ADAPT) or load_en (goes to STATIC).
- Counter widths are clog2-sized. There is no wrap-around: timeout_cnt saturates at TIMEOUT_CYC.
- start or load_en is ignored while RESETn is low. Asserting reset mid-calibration returns all outputs to reset values immediately (asynchronously).
- An undefined state encoding recovers to BYPASS.

Test Plan:
- Reset, then start; settled rises at cycle 100 after start and stays high. Required: op_mode = 01 from cycle 1; freeze = 1 at cycle 100+16; with Wr_est = 13'sd512 and Wj_est = -13'sd40, Wr_cfg = 512, Wj_cfg = -40; op_mode = 10 and done pulses at cycle 100+16+2.
- Settled toggles high for 10 cycles, low for 1, repeatedly (SETTLE_CYC = 16). Required: never enters CAPTURE; at cycle 4096 enters FAIL with timeout_err = 1, op_mode = 00, busy = 0.
- Same cycle settle_cnt reaches 16 and timeout_cnt reaches 4096 (TIMEOUT_CYC = 4096, settled first high at cycle 4080). Required: CAPTURE entered, timeout_err = 0.
- Raise abort during ADAPT at cycle 50. Required: next cycle state_o = 0 and op_mode = 00; earlier Wr_cfg retained. Assert start and load_en together. Required: load_en wins, STATIC with Wr_cfg = Wr_load.
- In STATIC, pulse load_en with Wr_load = -13'sd4096 and Wj_load = 13'sd4095. Required: Wr_cfg/Wj_cfg update next cycle, op_mode stays 10, done stays 0.
- Drop RESETn mid-ADAPT, between clock edges. Required: all outputs return to reset values before the next edge; the first start after release restarts cleanly at ADAPT.

Source files
------------

// File: rtl/iq_comp_seq_if.sv
// Bundle of the sequencer's host-side and iq_comp-side signals.
// slave = the sequencer, master = whatever drives it (host plus iq_comp model).
interface iq_comp_seq_if #(
   parameter int W_WIDTH = 13
);
   logic                      start;
   logic                      abort;
   logic                      load_en;
   logic signed [W_WIDTH-1:0] Wr_load;
   logic signed [W_WIDTH-1:0] Wj_load;
   logic                      settled;
   logic signed [W_WIDTH-1:0] Wr_est;
   logic signed [W_WIDTH-1:0] Wj_est;
   logic [1:0]                op_mode;
   logic                      freeze_iqcomp;
   logic signed [W_WIDTH-1:0] Wr_cfg;
   logic signed [W_WIDTH-1:0] Wj_cfg;
   logic                      busy;
   logic                      done;
   logic                      timeout_err;
   logic [2:0]                state_o;

   modport master (
      output start, abort, load_en, Wr_load, Wj_load, settled, Wr_est, Wj_est,
      input  op_mode, freeze_iqcomp, Wr_cfg, Wj_cfg, busy, done, timeout_err, state_o
   );

   modport slave (
      input  start, abort, load_en, Wr_load, Wj_load, settled, Wr_est, Wj_est,
      output op_mode, freeze_iqcomp, Wr_cfg, Wj_cfg, busy, done, timeout_err, state_o
   );
endinterface

// File: rtl/iq_comp_seq.sv
// Calibration sequencer for iq_comp: runs adaptive mode until the settled
// flag holds for SETTLE_CYC cycles (or TIMEOUT_CYC expires), freezes, grabs
// the converged weights and switches iq_comp to static mode with them.
module iq_comp_seq #(
   parameter int W_WIDTH     = 13,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic          clk,
   input logic          RESETn,
   iq_comp_seq_if.slave bus
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] S_MAX = SW'(SETTLE_CYC);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

   localparam logic [1:0] OP_BYP    = 2'b00;
   localparam logic [1:0] OP_ADAPT  = 2'b01;
   localparam logic [1:0] OP_STATIC = 2'b10;

   typedef enum logic [2:0] {
      BYPASS  = 3'd0,
      ADAPT   = 3'd1,
      CAPTURE = 3'd2,
      STATIC  = 3'd3,
      FAIL    = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                op_q, op_d;
   logic                      frz_q, frz_d;
   logic signed [W_WIDTH-1:0] wr_q, wr_d, wj_q, wj_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      terr_q, terr_d;
   logic [TW-1:0]             tcnt_q, tcnt_d, tcnt_inc;
   logic [SW-1:0]             scnt_q, scnt_d, scnt_inc;
   // second CAPTURE cycle marker; first cycle lets the freeze reach iq_comp
   logic                      cap_q, cap_d;

   // Next-state and next-output decode; abort > load_en > start > internal.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      frz_d   = frz_q;
      wr_d    = wr_q;
      wj_d    = wj_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      terr_d  = terr_q;
      tcnt_d  = tcnt_q;
      scnt_d  = scnt_q;
      cap_d   = cap_q;

      // both counters saturate so a long ADAPT can never wrap
      tcnt_inc = (tcnt_q == T_MAX) ? T_MAX : tcnt_q + 1'b1;
      scnt_inc = !bus.settled ? '0 : (scnt_q == S_MAX) ? S_MAX : scnt_q + 1'b1;

      if (bus.abort) begin
         state_d = BYPASS;
         op_d    = OP_BYP;
         frz_d   = 1'b0;
         busy_d  = 1'b0;
         tcnt_d  = '0;
         scnt_d  = '0;
         cap_d   = 1'b0;
      end else if (bus.load_en) begin
         wr_d    = bus.Wr_load;
         wj_d    = bus.Wj_load;
         state_d = STATIC;
         op_d    = OP_STATIC;
         frz_d   = 1'b1;
         busy_d  = 1'b0;
         terr_d  = 1'b0;
         tcnt_d  = '0;
         scnt_d  = '0;
         cap_d   = 1'b0;
      end else if (bus.start && state_q != CAPTURE) begin
         // a capture in flight is allowed to complete
         state_d = ADAPT;
         op_d    = OP_ADAPT;
         frz_d   = 1'b0;
         busy_d  = 1'b1;
         terr_d  = 1'b0;
         tcnt_d  = '0;
         scnt_d  = '0;
         cap_d   = 1'b0;
      end else begin
         case (state_q)
            BYPASS, STATIC, FAIL: ;
            ADAPT: begin
               tcnt_d = tcnt_inc;
               scnt_d = scnt_inc;
               if (scnt_inc == S_MAX) begin
                  // settling wins over a simultaneous timeout
                  state_d = CAPTURE;
                  frz_d   = 1'b1;
                  cap_d   = 1'b0;
               end else if (tcnt_inc == T_MAX) begin
                  state_d = FAIL;
                  op_d    = OP_BYP;
                  frz_d   = 1'b0;
                  busy_d  = 1'b0;
                  terr_d  = 1'b1;
               end
            end
            CAPTURE: begin
               if (!cap_q) begin
                  cap_d = 1'b1;
               end else begin
                  wr_d    = bus.Wr_est;
                  wj_d    = bus.Wj_est;
                  state_d = STATIC;
                  op_d    = OP_STATIC;
                  frz_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  cap_d   = 1'b0;
               end
            end
            default: begin
               state_d = BYPASS;
               op_d    = OP_BYP;
               frz_d   = 1'b0;
               busy_d  = 1'b0;
               tcnt_d  = '0;
               scnt_d  = '0;
               cap_d   = 1'b0;
            end
         endcase
      end
   end

   // State, counters and every output are registered here.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= BYPASS;
         op_q    <= OP_BYP;
         frz_q   <= 1'b0;
         wr_q    <= '0;
         wj_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         tcnt_q  <= '0;
         scnt_q  <= '0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         frz_q   <= frz_d;
         wr_q    <= wr_d;
         wj_q    <= wj_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         tcnt_q  <= tcnt_d;
         scnt_q  <= scnt_d;
         cap_q   <= cap_d;
      end
   end

   assign bus.op_mode       = op_q;
   assign bus.freeze_iqcomp = frz_q;
   assign bus.Wr_cfg        = wr_q;
   assign bus.Wj_cfg        = wj_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.timeout_err   = terr_q;
   assign bus.state_o       = state_q;
endmodule

// File: tb/tb_iq_comp_seq.sv
// Bench for iq_comp_seq: random settled/weight streams against a window-based
// reference model of the calibration outcome.
module tb_iq_comp_seq;
   localparam int W    = 13;
   localparam int S    = 16;
   localparam int T    = 4096;
   localparam int MAXC = T + 8;

   logic clk = 1'b0;
   logic RESETn;
   always #5 clk = ~clk;

   iq_comp_seq_if #(.W_WIDTH(W)) bus ();

   iq_comp_seq #(.W_WIDTH(W), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
      .clk    (clk),
      .RESETn (RESETn),
      .bus    (bus)
   );

   int vecs = 0;
   int errs = 0;

   // per-edge stimulus: index j is the value sampled at the j-th edge after start
   bit                  sp [0:MAXC];
   logic signed [W-1:0] er [0:MAXC];
   logic signed [W-1:0] ej [0:MAXC];
   logic signed [W-1:0] wr_m, wj_m;

   // {state_o, op_mode, freeze, busy, done, timeout_err}
   logic [8:0]     ctl;
   logic [2*W-1:0] cfg;
   assign ctl = {bus.state_o, bus.op_mode, bus.freeze_iqcomp, bus.busy, bus.done, bus.timeout_err};
   assign cfg = {bus.Wr_cfg, bus.Wj_cfg};

   function automatic logic [8:0] pk(input int st, input int op, input bit f, input bit b,
                                     input bit d, input bit t);
      return {3'(st), 2'(op), f, b, d, t};
   endfunction

   // edge index at which the first window of S consecutive settled samples completes
   // within the timeout budget; 0 means the calibration times out
   function automatic int first_qual();
      int run = 0;
      for (int j = 1; j <= T; j++) begin
         run = sp[j] ? run + 1 : 0;
         if (run >= S) return j;
      end
      return 0;
   endfunction

   // control outputs expected after edge j of a calibration whose outcome is kc
   function automatic logic [8:0] exp_at(input int kc, input int j);
      if (kc == 0) return (j < T) ? pk(1, 1, 0, 1, 0, 0) : pk(4, 0, 0, 0, 0, 1);
      if (j < kc) return pk(1, 1, 0, 1, 0, 0);
      if (j < kc + 2) return pk(2, 1, 1, 1, 0, 0);
      return pk(3, 2, 1, 0, (j == kc + 2), 0);
   endfunction

   task automatic fill_est();
      for (int j = 0; j <= MAXC; j++) begin
         er[j] = W'($urandom);
         ej[j] = W'($urandom);
      end
   endtask

   // pulse start, then stream sp/er/ej and check every cycle until the outcome settles
   task automatic run_cal(input string nm);
      int kc, jend;
      logic [8:0] e;
      kc   = first_qual();
      jend = (kc != 0) ? kc + 3 : T + 2;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.settled = 1'b0;
      for (int j = 0; j <= jend; j++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         if (kc != 0 && j == kc + 2) begin
            wr_m = er[j];
            wj_m = ej[j];
         end
         e = exp_at(kc, j);
         vecs++;
         if (ctl !== e) begin
            errs++;
            $display("FAIL %s ctl j=%0d got %h want %h", nm, j, ctl, e);
         end
         vecs++;
         if (cfg !== {wr_m, wj_m}) begin
            errs++;
            $display("FAIL %s cfg j=%0d got %h want %h", nm, j, cfg, {wr_m, wj_m});
         end
         bus.settled = sp[j+1];
         bus.Wr_est  = er[j+1];
         bus.Wj_est  = ej[j+1];
      end
      bus.settled = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vecs++;
      if (ctl !== 9'd0 || cfg !== '0) begin
         errs++;
         $display("FAIL reset_state got ctl=%h cfg=%h want 0", ctl, cfg);
      end
      bus.start   = 1'b1;
      bus.load_en = 1'b1;
      @(negedge clk);
      vecs++;
      if (ctl !== 9'd0 || cfg !== '0) begin
         errs++;
         $display("FAIL reset_ignores_start got ctl=%h cfg=%h want 0", ctl, cfg);
      end
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      RESETn      = 1'b1;
      wr_m        = '0;
      wj_m        = '0;
      @(negedge clk);
      vecs++;
      if (ctl !== 9'd0) begin
         errs++;
         $display("FAIL reset_release got ctl=%h want 0", ctl);
      end
   endtask

   task automatic test_converge();
      // settled raised during cycle 100 (first sampled at edge 101) and held
      for (int j = 0; j <= MAXC; j++) begin
         sp[j] = (j >= 101);
         er[j] = 13'sd512;
         ej[j] = -13'sd40;
      end
      run_cal("converge");
      vecs++;
      if (bus.Wr_cfg !== 13'sd512 || bus.Wj_cfg !== -13'sd40) begin
         errs++;
         $display("FAIL converge_weights got %0d/%0d want 512/-40", bus.Wr_cfg, bus.Wj_cfg);
      end
   endtask

   task automatic test_random_cal();
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j <= MAXC; j++) sp[j] = ($urandom_range(0, 15) != 0);
         fill_est();
         run_cal("random_cal");
      end
   endtask

   task automatic test_restart();
      @(negedge clk);
      bus.start   = 1'b1;
      bus.settled = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         @(negedge clk);
         vecs++;
         if (ctl !== pk(1, 1, 0, 1, 0, 0)) begin
            errs++;
            $display("FAIL restart_pre j=%0d got %h want %h", j, ctl, pk(1, 1, 0, 1, 0, 0));
         end
      end
      // restart with settled still high: the settle window must begin afresh
      for (int j = 0; j <= MAXC; j++) sp[j] = 1'b1;
      fill_est();
      run_cal("restart");
   endtask

   task automatic test_timeout();
      // 10 high / 1 low never forms a 16-long window
      for (int j = 0; j <= MAXC; j++) sp[j] = (j > 0) && (((j - 1) % 11) < 10);
      fill_est();
      run_cal("timeout");
      repeat (3) begin
         @(negedge clk);
         vecs++;
         if (ctl !== pk(4, 0, 0, 0, 0, 1)) begin
            errs++;
            $display("FAIL timeout_hold got %h want %h", ctl, pk(4, 0, 0, 0, 0, 1));
         end
      end
   endtask

   task automatic test_simultaneous();
      // window completes on the very edge the timeout expires
      for (int j = 0; j <= MAXC; j++) sp[j] = (j >= T - S + 1);
      fill_est();
      run_cal("simultaneous");
   endtask

   task automatic test_abort();
      logic signed [W-1:0] lr, lj;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.settled = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (50) begin
         @(posedge clk);
         @(negedge clk);
      end
      vecs++;
      if (ctl !== pk(1, 1, 0, 1, 0, 0)) begin
         errs++;
         $display("FAIL abort_pre got %h want %h", ctl, pk(1, 1, 0, 1, 0, 0));
      end
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vecs++;
      if (ctl !== 9'd0 || cfg !== {wr_m, wj_m}) begin
         errs++;
         $display("FAIL abort_bypass got ctl=%h cfg=%h want 0/%h", ctl, cfg, {wr_m, wj_m});
      end
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vecs++;
      if (ctl !== 9'd0) begin
         errs++;
         $display("FAIL abort_over_start got %h want 0", ctl);
      end
      lr = W'($urandom);
      lj = W'($urandom);
      bus.abort   = 1'b0;
      bus.load_en = 1'b1;
      bus.Wr_load = lr;
      bus.Wj_load = lj;
      @(posedge clk);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      wr_m = lr;
      wj_m = lj;
      vecs++;
      if (ctl !== pk(3, 2, 1, 0, 0, 0) || cfg !== {wr_m, wj_m}) begin
         errs++;
         $display("FAIL load_over_start got ctl=%h cfg=%h want %h/%h",
                  ctl, cfg, pk(3, 2, 1, 0, 0, 0), {wr_m, wj_m});
      end
   endtask

   task automatic test_static_load();
      logic signed [W-1:0] lr, lj;
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin
            lr = 13'h1000;   // most negative weight
            lj = 13'h0fff;   // most positive weight
         end else begin
            lr = W'($urandom);
            lj = W'($urandom);
         end
         bus.load_en = 1'b1;
         bus.Wr_load = lr;
         bus.Wj_load = lj;
         @(posedge clk);
         @(negedge clk);
         bus.load_en = 1'b0;
         wr_m = lr;
         wj_m = lj;
         vecs++;
         if (ctl !== pk(3, 2, 1, 0, 0, 0) || cfg !== {wr_m, wj_m}) begin
            errs++;
            $display("FAIL static_load k=%0d got ctl=%h cfg=%h want %h/%h",
                     k, ctl, cfg, pk(3, 2, 1, 0, 0, 0), {wr_m, wj_m});
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.start   = 1'b1;
      bus.settled = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      vecs++;
      if (ctl !== pk(1, 1, 0, 1, 0, 0)) begin
         errs++;
         $display("FAIL areset_pre got %h want %h", ctl, pk(1, 1, 0, 1, 0, 0));
      end
      @(posedge clk);
      #2 RESETn = 1'b0;
      #1;
      vecs++;
      if (ctl !== 9'd0 || cfg !== '0) begin
         errs++;
         $display("FAIL areset_immediate got ctl=%h cfg=%h want 0", ctl, cfg);
      end
      wr_m = '0;
      wj_m = '0;
      bus.start   = 1'b1;
      bus.load_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if (ctl !== 9'd0 || cfg !== '0) begin
         errs++;
         $display("FAIL areset_held got ctl=%h cfg=%h want 0", ctl, cfg);
      end
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      RESETn      = 1'b1;
      for (int j = 0; j <= MAXC; j++) sp[j] = ($urandom_range(0, 31) != 0);
      fill_est();
      run_cal("post_reset");
   endtask

   initial begin
      RESETn      = 1'b0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.load_en = 1'b0;
      bus.Wr_load = '0;
      bus.Wj_load = '0;
      bus.settled = 1'b0;
      bus.Wr_est  = '0;
      bus.Wj_est  = '0;
      wr_m        = '0;
      wj_m        = '0;
      test_reset();
      test_converge();
      test_random_cal();
      test_restart();
      test_timeout();
      test_simultaneous();
      test_abort();
      test_static_load();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired after %0d vectors, %0d miscompares", vecs, errs);
      $fatal(1, "watchdog");
   end
endmodule
